// File: rtl/aes_rkey_buf_if.sv
// Bus between the AES key expander / decrypt datapath and the round-key buffer.
// The master drives the load strobe, expander words and read requests; the slave returns keys.
interface aes_rkey_buf_if;
    logic         kld;
    logic [31:0]  wo_0;
    logic [31:0]  wo_1;
    logic [31:0]  wo_2;
    logic [31:0]  wo_3;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic         strm_start;
    logic         key_ready;
    logic         strm_busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_vld;
    logic         rd_err;

    modport master (
        output kld, wo_0, wo_1, wo_2, wo_3, rd_en, rd_idx, strm_start,
        input  key_ready, strm_busy, rk_out, rk_idx, rk_vld, rd_err
    );

    modport slave (
        input  kld, wo_0, wo_1, wo_2, wo_3, rd_en, rd_idx, strm_start,
        output key_ready, strm_busy, rk_out, rk_idx, rk_vld, rd_err
    );
endinterface

// File: rtl/aes_rkey_buf.sv
// Captures the 11 AES-128 round keys from the expander and serves them by index
// or as a descending rkNR..rk0 stream for the decrypt datapath.
//
// state | meaning
// IDLE  | nothing loaded since reset
// FILL  | capturing expander output, one round key per edge
// DONE  | all NR+1 keys stored, key_ready asserted
module aes_rkey_buf #(
    parameter int NR = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    aes_rkey_buf_if.slave bus_s
);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

    state_e       state_q;
    logic [3:0]   cnt_q;
    logic         key_ready_q;
    logic         strm_busy_q;
    logic         rk_vld_q;
    logic         rd_err_q;
    logic [127:0] rk_out_q;
    logic [3:0]   rk_idx_q;
    logic [127:0] slot_q [0:NR];

    logic         cap_en;
    logic [127:0] wo_cat;

    assign cap_en = (state_q == FILL) && !bus_s.kld;
    assign wo_cat = {bus_s.wo_0, bus_s.wo_1, bus_s.wo_2, bus_s.wo_3};

    // Storage carries no reset; it is only observable once key_ready is set.
    always_ff @(posedge clk_i) begin
        if (cap_en) begin
            slot_q[cnt_q] <= wo_cat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            key_ready_q <= 1'b0;
            strm_busy_q <= 1'b0;
            rk_vld_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rk_out_q    <= '0;
            rk_idx_q    <= 4'd0;
        end else begin
            rk_vld_q <= 1'b0;
            rd_err_q <= 1'b0;
            if (bus_s.kld) begin
                state_q     <= FILL;
                cnt_q       <= 4'd0;
                key_ready_q <= 1'b0;
                strm_busy_q <= 1'b0;
            end else begin
                if (state_q == FILL) begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        key_ready_q <= 1'b1;
                    end
                end
                // rk_idx_q doubles as the stream pointer; idx 0 presented means done.
                if (strm_busy_q) begin
                    rd_err_q <= bus_s.rd_en;
                    if (rk_idx_q == 4'd0) begin
                        strm_busy_q <= 1'b0;
                    end else begin
                        rk_out_q <= slot_q[rk_idx_q - 4'd1];
                        rk_idx_q <= rk_idx_q - 4'd1;
                        rk_vld_q <= 1'b1;
                    end
                end else if (bus_s.strm_start) begin
                    if (key_ready_q) begin
                        strm_busy_q <= 1'b1;
                        rk_out_q    <= slot_q[LAST];
                        rk_idx_q    <= LAST;
                        rk_vld_q    <= 1'b1;
                        rd_err_q    <= bus_s.rd_en;
                    end else begin
                        rd_err_q <= 1'b1;
                    end
                end else if (bus_s.rd_en) begin
                    if (key_ready_q && (bus_s.rd_idx <= LAST)) begin
                        rk_out_q <= slot_q[bus_s.rd_idx];
                        rk_idx_q <= bus_s.rd_idx;
                        rk_vld_q <= 1'b1;
                    end else begin
                        rd_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus_s.key_ready = key_ready_q;
    assign bus_s.strm_busy = strm_busy_q;
    assign bus_s.rk_vld    = rk_vld_q;
    assign bus_s.rd_err    = rd_err_q;
    assign bus_s.rk_out    = rk_out_q;
    assign bus_s.rk_idx    = rk_idx_q;
endmodule

// File: doc/aes_rkey_buf.md
Name: aes_rkey_buf

Overview:
- Round-key store placed directly downstream of the 128-bit AES key expander. Consumes its per-cycle output (wo_0..wo_3) after a key load and captures all 11 round keys.
- Serves those keys to the decryption datapath, which needs them in reverse order (rk10 first). Two read modes: random-access by round index, or an auto-sequenced descending stream.

Parameters:
- NR, 10, number of AES rounds. 11 stored keys, indices 0..NR. Only 10 (AES-128) is supported.

Ports:
- clk  in  1  rising-edge clock, shared with the key expander
- rst  in  1  asynchronous, active-low reset
- kld  in  1  same key-load strobe that drives the expander
- wo_0  in  32  expander word 0 (key bits 127:96)
- wo_1  in  32  expander word 1
- wo_2  in  32  expander word 2
- wo_3  in  32  expander word 3 (bits 31:0)
- key_ready  out  1  all NR+1 round keys captured and valid
- rd_en  in  1  random-access read request
- rd_idx  in  4  round index for the random read
- strm_start  in  1  start descending stream rkNR..rk0
- strm_busy  out  1  stream in progress
- rk_out  out  128  round key {w0,w1,w2,w3}, registered
- rk_idx  out  4  index of the key on rk_out
- rk_vld  out  1  rk_out/rk_idx valid this cycle
- rd_err  out  1  one-cycle pulse: rejected read

Behaviour:
- Reset (rst=0, asynchronous):
  - key_ready=0, strm_busy=0, rk_vld=0, rd_err=0, rk_out=0, rk_idx=0.
  - Fill counter = 0; fill FSM = IDLE.
  - Key storage is not reset; it is unobservable until key_ready=1.
- Expander timing: kld sampled high at edge E0 makes the expander present rk0 after E0, then rk1 after E1, and so on up to rk10 after E10.
- Fill FSM (IDLE, FILL, DONE):
  - kld=1 at any edge, in any state: go to FILL, counter=0, key_ready=0 in the following cycle. Any active stream is aborted (strm_busy=0, rk_vld=0).
  - In FILL, while kld=0 at an edge: store {wo_0,wo_1,wo_2,wo_3} into slot[counter], then increment counter.
  - Capture of rk0..rk10 occurs at edges E1..E11. At E11 (counter==NR) go to DONE; key_ready=1 after E11.
  - kld held high for several cycles: fill restarts on every high cycle; the last high cycle defines E0.
  - kld reasserted mid-FILL: restart from slot 0; no partial key set is ever flagged ready.
- Random read:
  - rd_en=1 at edge, with key_ready=1, idx<=NR, strm_busy=0: next cycle rk_out=slot[idx], rk_idx=idx, rk_vld=1. Latency 1, one read per cycle, back-to-back allowed.
  - Rejected with rd_err=1 and rk_vld=0 for one cycle if rd_en=1 while key_ready=0, idx>NR, or strm_busy=1.
- Stream:
  - strm_start=1 with key_ready=1 and strm_busy=0: strm_busy=1 from the next cycle.
  - rk_out then steps through slot[NR] down to slot[0] on 11 consecutive cycles, rk_vld=1 throughout, rk_idx = NR..0.
  - strm_busy drops in the cycle after rk_idx=0 is presented.
  - strm_start while key_ready=0: rd_err pulse, no stream. strm_start while busy: ignored, no error.
  - strm_start and rd_en in the same cycle: stream wins; the rd_en is rejected with rd_err.
- Between reads: rk_out holds its last value; rk_vld=0.
- rd_err has priority over nothing: it is only a flag, and output data is unchanged when it fires.

Test Plan:
- Reset, then load key 000102030405060708090a0b0c0d0e0f with kld for 1 cycle:
  - key_ready rises exactly 11 edges after the kld edge.
  - Read idx 0 gives 000102030405060708090a0b0c0d0e0f.
  - Read idx 10 gives 13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197).
- strm_start after ready:
  - 11 consecutive rk_vld cycles with rk_idx 10..0.
  - First key 13111d7f..., last 00010203...
  - strm_busy drops the cycle after rk_idx=0.
- Reject cases: rd_en during FILL, rd_idx=11 after ready, and rd_en during stream each give a single rd_err pulse with rk_vld=0.
- kld reasserted at the 5th capture:
  - key_ready stays 0, then rises 11 edges after the new kld edge.
  - All 11 keys match the second key.
- kld asserted mid-stream: strm_busy and rk_vld go low the next cycle; key_ready=0 until the refill completes.
- rst asserted asynchronously mid-FILL and mid-stream: all outputs go to 0 immediately, without a clock edge; the FSM returns to IDLE.
